// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Two-requester AXI read-channel arbiter with a single outstanding burst.
// A round-robin choice between s0 and s1 is made in IDLE. The winner's AR is
// latched and presented on the shared master AR channel. The master R channel
// is then routed to the owner until the RLAST beat.
//
// Ports
//   clk_100Mhz, rst          : clock, synchronous active-high reset
//   sN_AR{ADDR,LEN,VALID}    : requester N read address request (N = 0,1)
//   sN_ARREADY               : requester N address accepted (combinational)
//   sN_R{DATA,VALID,LAST}    : requester N read data, routed from master
//   sN_RREADY                : requester N read ready
//   m_AR{ADDR,LEN,VALID}     : shared master address channel (registered)
//   m_ARREADY                : master address accepted
//   m_AR{SIZE,BURST,CACHE}   : constant 8-byte INCR cacheable attributes
//   m_R{DATA,VALID,LAST}     : shared master read data channel
//   m_RREADY                 : routed from the owner's RREADY
//   state, owner             : debug visibility of FSM state and burst owner
//   err_len                  : sticky burst length mismatch flag
//   burst_cnt0, burst_cnt1   : completed bursts per requester (wrapping)
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] s0_ARADDR,
    input  logic [7:0]                s0_ARLEN,
    input  logic                      s0_ARVALID,
    output logic                      s0_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0] s0_RDATA,
    output logic                      s0_RVALID,
    output logic                      s0_RLAST,
    input  logic                      s0_RREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] s1_ARADDR,
    input  logic [7:0]                s1_ARLEN,
    input  logic                      s1_ARVALID,
    output logic                      s1_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0] s1_RDATA,
    output logic                      s1_RVALID,
    output logic                      s1_RLAST,
    input  logic                      s1_RREADY,
    output logic [AXI_ADDR_WIDTH-1:0] m_ARADDR,
    output logic [7:0]                m_ARLEN,
    output logic                      m_ARVALID,
    input  logic                      m_ARREADY,
    output logic [2:0]                m_ARSIZE,
    output logic [1:0]                m_ARBURST,
    output logic [3:0]                m_ARCACHE,
    input  logic [AXI_DATA_WIDTH-1:0] m_RDATA,
    input  logic                      m_RVALID,
    input  logic                      m_RLAST,
    output logic                      m_RREADY,
    output logic [1:0]                state,
    output logic                      owner,
    output logic                      err_len,
    output logic [15:0]               burst_cnt0,
    output logic [15:0]               burst_cnt1
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_SEND = 2'd1,
        DATA_READ = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant;
    logic [7:0]  beat_cnt;
    logic        winner, grant, in_data, beat, done;
    logic [15:0] burst_cnt0_d, burst_cnt1_d;

    // On a tie the requester that did not own the previous burst wins.
    assign winner     = (s0_ARVALID && s1_ARVALID) ? ~last_grant : s1_ARVALID;
    assign s0_ARREADY = (state_q == IDLE) && s0_ARVALID && !winner;
    assign s1_ARREADY = (state_q == IDLE) && s1_ARVALID &&  winner;
    assign grant      = (s0_ARVALID && s0_ARREADY) || (s1_ARVALID && s1_ARREADY);

    assign in_data  = (state_q == DATA_READ);
    assign m_RREADY = in_data && (owner ? s1_RREADY : s0_RREADY);
    assign beat     = in_data && m_RVALID && m_RREADY;
    assign done     = beat && m_RLAST;

    assign s0_RVALID = in_data && !owner && m_RVALID;
    assign s0_RLAST  = in_data && !owner && m_RLAST;
    assign s1_RVALID = in_data &&  owner && m_RVALID;
    assign s1_RLAST  = in_data &&  owner && m_RLAST;
    assign s0_RDATA  = m_RDATA;
    assign s1_RDATA  = m_RDATA;

    assign m_ARSIZE  = 3'b011;
    assign m_ARBURST = 2'b01;
    assign m_ARCACHE = 4'b1111;
    assign state     = state_q;

    always_ff @(posedge clk_100Mhz) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (grant)     state_d = ADDR_SEND;
            ADDR_SEND: if (m_ARREADY) state_d = DATA_READ;
            DATA_READ: if (done)      state_d = IDLE;
            default:                  state_d = IDLE;  // unused encoding recovers
        endcase
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            m_ARVALID  <= 1'b0;
            m_ARADDR   <= '0;
            m_ARLEN    <= 8'd0;
            err_len    <= 1'b0;
            beat_cnt   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        m_ARADDR  <= winner ? s1_ARADDR : s0_ARADDR;
                        m_ARLEN   <= winner ? s1_ARLEN  : s0_ARLEN;
                        owner     <= winner;
                        m_ARVALID <= 1'b1;
                    end
                end
                ADDR_SEND: begin
                    if (m_ARREADY) begin
                        m_ARVALID <= 1'b0;
                        beat_cnt  <= 8'd0;
                    end
                end
                DATA_READ: begin
                    // beat_cnt holds the index of the current beat, so the
                    // RLAST beat of a well-formed burst sees beat_cnt == ARLEN.
                    if (beat) begin
                        if (m_RLAST) begin
                            if (beat_cnt != m_ARLEN) err_len <= 1'b1;
                            last_grant <= owner;
                        end else begin
                            if (beat_cnt == m_ARLEN) err_len <= 1'b1;
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: m_ARVALID <= 1'b0;
            endcase
        end
    end

    always_comb begin
        burst_cnt0_d = burst_cnt0 + 16'(done && !owner);
        burst_cnt1_d = burst_cnt1 + 16'(done &&  owner);
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            burst_cnt0 <= 16'd0;
            burst_cnt1 <= 16'd0;
        end else begin
            burst_cnt0 <= burst_cnt0_d;
            burst_cnt1 <= burst_cnt1_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Self-checking bench for axi_rd_arbiter. An arbitration vector table is
// followed by directed burst sequences: AR delay, RREADY stall, short and long
// RLAST, mid-burst reset and counter wrap. A randomized run is then checked
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk_100Mhz = 1'b0;
    logic          rst;
    logic [AW-1:0] s0_ARADDR, s1_ARADDR, m_ARADDR;
    logic [7:0]    s0_ARLEN, s1_ARLEN, m_ARLEN;
    logic          s0_ARVALID, s1_ARVALID, s0_ARREADY, s1_ARREADY;
    logic [DW-1:0] s0_RDATA, s1_RDATA, m_RDATA;
    logic          s0_RVALID, s1_RVALID, s0_RLAST, s1_RLAST, s0_RREADY, s1_RREADY;
    logic          m_ARVALID, m_ARREADY, m_RVALID, m_RLAST, m_RREADY;
    logic [2:0]    m_ARSIZE;
    logic [1:0]    m_ARBURST, state;
    logic [3:0]    m_ARCACHE;
    logic          owner, err_len;
    logic [15:0]   burst_cnt0, burst_cnt1;

    always #5 clk_100Mhz = ~clk_100Mhz;

    axi_rd_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .clk_100Mhz(clk_100Mhz), .rst(rst),
        .s0_ARADDR(s0_ARADDR), .s0_ARLEN(s0_ARLEN), .s0_ARVALID(s0_ARVALID), .s0_ARREADY(s0_ARREADY),
        .s0_RDATA(s0_RDATA), .s0_RVALID(s0_RVALID), .s0_RLAST(s0_RLAST), .s0_RREADY(s0_RREADY),
        .s1_ARADDR(s1_ARADDR), .s1_ARLEN(s1_ARLEN), .s1_ARVALID(s1_ARVALID), .s1_ARREADY(s1_ARREADY),
        .s1_RDATA(s1_RDATA), .s1_RVALID(s1_RVALID), .s1_RLAST(s1_RLAST), .s1_RREADY(s1_RREADY),
        .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
        .m_ARSIZE(m_ARSIZE), .m_ARBURST(m_ARBURST), .m_ARCACHE(m_ARCACHE),
        .m_RDATA(m_RDATA), .m_RVALID(m_RVALID), .m_RLAST(m_RLAST), .m_RREADY(m_RREADY),
        .state(state), .owner(owner), .err_len(err_len),
        .burst_cnt0(burst_cnt0), .burst_cnt1(burst_cnt1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int beats_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_100Mhz);
        #1;
    endtask

    task automatic idle_inputs();
        s0_ARADDR = '0; s0_ARLEN = '0; s0_ARVALID = 0; s0_RREADY = 0;
        s1_ARADDR = '0; s1_ARLEN = '0; s1_ARVALID = 0; s1_RREADY = 0;
        m_ARREADY = 0; m_RDATA = '0; m_RVALID = 0; m_RLAST = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic set_req(input bit who, input bit v, input logic [31:0] a, input logic [7:0] l);
        if (who) begin s1_ARVALID = v; s1_ARADDR = a; s1_ARLEN = l; end
        else     begin s0_ARVALID = v; s0_ARADDR = a; s0_ARLEN = l; end
    endtask

    // Requests alone, expects the grant, and completes the handshake.
    task automatic req_grant(input bit who, input logic [31:0] a, input logic [7:0] l);
        set_req(who, 1, a, l);
        #1;
        chk("grant ARREADY", who ? s1_ARREADY : s0_ARREADY, 1);
        cyc();
        set_req(who, 0, a, l);
        chk("owner after grant", owner, who);
    endtask

    // Holds m_ARREADY low for dly cycles and counts m_ARVALID-high cycles.
    task automatic addr_phase(input int dly, input logic [31:0] a, input logic [7:0] l);
        int hi = 0;
        for (int k = 0; k <= dly; k++) begin
            m_ARREADY = (k == dly);
            #1;
            if (m_ARVALID) hi++;
            chk("m_ARADDR hold", m_ARADDR, a);
            chk("m_ARLEN hold", m_ARLEN, l);
            cyc();
        end
        m_ARREADY = 0;
        #1;
        chk("m_ARVALID cycles", hi, dly + 1);
        chk("m_ARVALID drop", m_ARVALID, 0);
    endtask

    // Streams beats with RLAST at index last_idx; the owner stalls RREADY for
    // stall_len cycles at beat stall_at; stops early once stop_at beats pass.
    task automatic data_phase(input bit who, input int last_idx, input int stall_at,
                              input int stall_len, input int stop_at);
        int beats = 0;
        int stall = stall_len;
        bit rr;
        bit fin = 0;
        for (int g = 0; g < 2000 && !fin; g++) begin
            rr = !(beats == stall_at && stall > 0);
            if (!rr) stall--;
            if (who) begin s1_RREADY = rr; s0_RREADY = 1; end
            else     begin s0_RREADY = rr; s1_RREADY = 1; end
            m_RVALID = 1;
            m_RDATA  = {32'(beats), 32'($urandom)};
            m_RLAST  = (beats == last_idx);
            #1;
            chk("m_RREADY route", m_RREADY, rr);
            chk("owner RVALID", who ? s1_RVALID : s0_RVALID, 1);
            chk("owner RLAST", who ? s1_RLAST : s0_RLAST, m_RLAST);
            chk("other RVALID", who ? s0_RVALID : s1_RVALID, 0);
            chk("other RLAST", who ? s0_RLAST : s1_RLAST, 0);
            chk("RDATA pass", who ? s1_RDATA : s0_RDATA, m_RDATA);
            if (rr) begin
                fin = m_RLAST || (beats + 1 == stop_at);
                beats++;
            end
            cyc();
        end
        m_RVALID = 0; m_RLAST = 0; s0_RREADY = 0; s1_RREADY = 0;
        chk("data phase finished", fin, 1);
        beats_g = beats;
    endtask

    task automatic burst(input bit who, input logic [31:0] a, input logic [7:0] l, input int dly,
                         input int last_idx, input int stall_at, input int stall_len);
        req_grant(who, a, l);
        addr_phase(dly, a, l);
        data_phase(who, last_idx, stall_at, stall_len, 1000);
    endtask

    typedef struct {
        bit          v0, v1;
        bit          r0, r1;
        logic [15:0] c0, c1;
    } vec_t;

    vec_t tbl[9];

    // Randomized-run reference state (transaction level)
    bit          pend[2];
    logic [31:0] paddr[2];
    logic [7:0]  plen[2];
    bit          rr_r[2];
    bit          busy, ar_done, m_last, m_own, has_w, w, indata;
    logic [31:0] caddr;
    logic [7:0]  clen;
    int          mbeat;
    int          mcnt[2];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0};  // first tie -> s0
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd2};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 16'd2};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 16'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 16'd3};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd4, 16'd3};

        do_reset();

        // Reset state; R routing must stay closed even with RVALID/RREADY up
        m_RVALID = 1; s0_RREADY = 1; s1_RREADY = 1;
        #1;
        chk("rst state", state, 0);
        chk("rst owner", owner, 0);
        chk("rst m_ARVALID", m_ARVALID, 0);
        chk("rst m_ARADDR", m_ARADDR, 0);
        chk("rst m_ARLEN", m_ARLEN, 0);
        chk("rst err_len", err_len, 0);
        chk("rst burst_cnt0", burst_cnt0, 0);
        chk("rst burst_cnt1", burst_cnt1, 0);
        chk("rst m_RREADY", m_RREADY, 0);
        chk("rst s0_RVALID", s0_RVALID, 0);
        chk("rst ARREADY idle", {s0_ARREADY, s1_ARREADY}, 0);
        chk("m_ARSIZE", m_ARSIZE, 3'b011);
        chk("m_ARBURST", m_ARBURST, 2'b01);
        chk("m_ARCACHE", m_ARCACHE, 4'b1111);
        m_RVALID = 0; s0_RREADY = 0; s1_RREADY = 0;

        // Arbitration table: each grant is followed by a one-beat burst, and
        // the next record is offered in the first IDLE cycle afterwards.
        for (int i = 0; i < 9; i++) begin
            s0_ARVALID = tbl[i].v0; s0_ARADDR = 32'hA000_0000 + 32'(i); s0_ARLEN = 0;
            s1_ARVALID = tbl[i].v1; s1_ARADDR = 32'hB000_0000 + 32'(i); s1_ARLEN = 0;
            #1;
            chk("tbl s0_ARREADY", s0_ARREADY, tbl[i].r0);
            chk("tbl s1_ARREADY", s1_ARREADY, tbl[i].r1);
            cyc();
            s0_ARVALID = 0; s1_ARVALID = 0;
            if (tbl[i].r0 || tbl[i].r1) begin
                chk("tbl owner", owner, tbl[i].r1);
                chk("tbl state addr", state, 1);
                addr_phase(1, (tbl[i].r1 ? 32'hB000_0000 : 32'hA000_0000) + 32'(i), 8'd0);
                data_phase(tbl[i].r1, 0, -1, 0, 1000);
            end
            chk("tbl burst_cnt0", burst_cnt0, tbl[i].c0);
            chk("tbl burst_cnt1", burst_cnt1, tbl[i].c1);
        end

        // s0 alone, 64 beats, AR accepted after 3 wait cycles
        do_reset();
        burst(0, 32'h0100_0000, 8'd63, 3, 63, -1, 0);
        chk("long burst beats", beats_g, 64);
        chk("long burst cnt0", burst_cnt0, 1);
        chk("long burst err", err_len, 0);
        chk("long burst idle", state, 0);

        // s1 stalls RREADY 10 cycles mid-burst
        burst(1, 32'h0200_0000, 8'd63, 0, 63, 20, 10);
        chk("stall beats", beats_g, 64);
        chk("stall cnt1", burst_cnt1, 1);
        chk("stall err", err_len, 0);

        // Early RLAST at beat 31 of a 64-beat burst
        burst(0, 32'h0300_0000, 8'd63, 1, 31, -1, 0);
        chk("early last beats", beats_g, 32);
        chk("early last err", err_len, 1);
        chk("early last idle", state, 0);
        burst(1, 32'h0300_1000, 8'd1, 0, 1, -1, 0);
        chk("err sticky", err_len, 1);
        chk("early cnt0", burst_cnt0, 2);
        chk("early cnt1", burst_cnt1, 2);

        // Reset after 20 beats of a DATA_READ burst
        req_grant(1, 32'h0400_0000, 8'd63);
        addr_phase(0, 32'h0400_0000, 8'd63);
        data_phase(1, 63, -1, 0, 20);
        chk("abort beats", beats_g, 20);
        chk("abort in data", state, 2);
        rst = 1; m_RVALID = 1; s1_RREADY = 1;
        cyc();
        rst = 0;
        #1;
        chk("abort state", state, 0);
        chk("abort m_RREADY", m_RREADY, 0);
        chk("abort s1_RVALID", s1_RVALID, 0);
        chk("abort m_ARVALID", m_ARVALID, 0);
        chk("abort cnt0", burst_cnt0, 0);
        chk("abort cnt1", burst_cnt1, 0);
        chk("abort err", err_len, 0);
        m_RVALID = 0; s1_RREADY = 0;
        burst(1, 32'h0500_0000, 8'd2, 2, 2, -1, 0);
        chk("post-abort beats", beats_g, 3);
        chk("post-abort cnt1", burst_cnt1, 1);
        chk("post-abort err", err_len, 0);

        // Counter reaches ARLEN with no RLAST: flag, keep waiting for RLAST
        burst(0, 32'h0600_0000, 8'd3, 0, 5, -1, 0);
        chk("late last beats", beats_g, 6);
        chk("late last err", err_len, 1);
        chk("late last idle", state, 0);
        chk("late last cnt0", burst_cnt0, 1);

        // burst_cnt0 preset to 0xFFFF, one more s0 burst wraps it
        force dut.burst_cnt0_d = 16'hFFFF;
        cyc();
        release dut.burst_cnt0_d;
        chk("preset cnt0", burst_cnt0, 16'hFFFF);
        burst(0, 32'h0700_0000, 8'd0, 0, 0, -1, 0);
        chk("wrap cnt0", burst_cnt0, 0);
        chk("wrap cnt1", burst_cnt1, 1);

        // Randomized traffic against the reference model
        do_reset();
        busy = 0; ar_done = 0; m_last = 1; m_own = 0; mbeat = 0; caddr = '0; clen = '0;
        for (int n = 0; n < 2; n++) begin pend[n] = 0; mcnt[n] = 0; paddr[n] = '0; plen[n] = '0; end
        for (int c = 0; c < 4000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n]) begin
                    if ($urandom_range(2) == 0) begin
                        pend[n] = 1; paddr[n] = $urandom; plen[n] = 8'($urandom_range(5));
                    end
                end else if ($urandom_range(15) == 0) begin
                    pend[n] = 0;  // withdraw before grant
                end
                rr_r[n] = ($urandom_range(3) != 0);
            end
            set_req(0, pend[0], paddr[0], plen[0]);
            set_req(1, pend[1], paddr[1], plen[1]);
            s0_RREADY = rr_r[0]; s1_RREADY = rr_r[1];
            m_ARREADY = ($urandom_range(2) == 0);
            m_RVALID  = busy && ar_done && ($urandom_range(1) == 1);
            m_RDATA   = {32'($urandom), 32'($urandom)};
            m_RLAST   = m_RVALID && (mbeat == int'(clen));
            has_w  = pend[0] || pend[1];
            w      = (pend[0] && pend[1]) ? !m_last : pend[1];
            indata = busy && ar_done;
            #1;
            chk("rnd s0_ARREADY", s0_ARREADY, !busy && has_w && !w);
            chk("rnd s1_ARREADY", s1_ARREADY, !busy && has_w && w);
            chk("rnd m_ARVALID", m_ARVALID, busy && !ar_done);
            if (busy && !ar_done) begin
                chk("rnd m_ARADDR", m_ARADDR, caddr);
                chk("rnd m_ARLEN", m_ARLEN, clen);
            end
            chk("rnd m_RREADY", m_RREADY, indata && rr_r[m_own]);
            chk("rnd s0_RVALID", s0_RVALID, indata && !m_own && m_RVALID);
            chk("rnd s1_RVALID", s1_RVALID, indata && m_own && m_RVALID);
            chk("rnd s0_RLAST", s0_RLAST, indata && !m_own && m_RLAST);
            chk("rnd s1_RLAST", s1_RLAST, indata && m_own && m_RLAST);
            chk("rnd s1_RDATA", s1_RDATA, m_RDATA);
            if (!busy) begin
                if (has_w) begin
                    busy = 1; ar_done = 0; m_own = w; m_last = w;
                    caddr = paddr[w]; clen = plen[w]; pend[w] = 0;
                end
            end else if (!ar_done) begin
                if (m_ARREADY) begin ar_done = 1; mbeat = 0; end
            end else if (m_RVALID && rr_r[m_own]) begin
                if (mbeat == int'(clen)) begin busy = 0; mcnt[m_own]++; end
                else mbeat++;
            end
            cyc();
        end
        chk("rnd err_len", err_len, 0);
        chk("rnd burst_cnt0", burst_cnt0, 16'(mcnt[0]));
        chk("rnd burst_cnt1", burst_cnt1, 16'(mcnt[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
